// File: rtl/writeback_bypass_history_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_bypass_history_pkg
// Description : Shared types and constants for the writeback bypass history.
//               Holds the history entry layout and the lane / register index
//               widths that the history and its lane muxes agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_bypass_history_pkg;

    localparam int C_LANES         = 16;
    localparam int C_LANE_WIDTH    = 32;
    localparam int C_REG_IDX_WIDTH = 7;
    localparam int C_VALUE_WIDTH   = C_LANES * C_LANE_WIDTH;

    // One committed writeback. A scalar entry carries its data in lane 0.
    typedef struct packed {
        logic                       valid;
        logic                       is_vector;
        logic [C_REG_IDX_WIDTH-1:0] reg_idx;
        logic [C_LANES-1:0]         mask;
        logic [C_VALUE_WIDTH-1:0]   value;
    } bypass_entry_t;

    // Scalar writebacks only ever own lane 0, whatever the mask input says.
    function automatic logic [C_LANES-1:0] capture_mask(
        input logic               is_vector,
        input logic [C_LANES-1:0] mask
    );
        return is_vector ? mask : C_LANES'(1);
    endfunction

endpackage : writeback_bypass_history_pkg
`default_nettype wire

// File: rtl/writeback_bypass_history_bypass_lane_select.sv
`default_nettype none
// ============================================================================
// Module      : bypass_lane_select
// Description : Priority mux for one 32-bit lane of one operand port. Picks
//               the lowest-index selected history entry, otherwise passes the
//               register-file data through.
// Ports       : i_sel        - per-entry "entry owns this lane" flags
//               i_entry_data - lane data of every entry, entry i at [i*W +: W]
//               i_rf_data    - raw register-file lane data
//               o_data       - corrected lane data
//               o_hit        - lane was substituted
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_lane_select
    import writeback_bypass_history_pkg::*;
#(
    parameter int HISTORY_DEPTH = 2,
    parameter int LANE_WIDTH    = C_LANE_WIDTH
) (
    input  logic [HISTORY_DEPTH-1:0]            i_sel,
    input  logic [HISTORY_DEPTH*LANE_WIDTH-1:0] i_entry_data,
    input  logic [LANE_WIDTH-1:0]               i_rf_data,
    output logic [LANE_WIDTH-1:0]               o_data,
    output logic                                o_hit
);

    // Walk oldest to newest so the newest selected entry is the last writer.
    always_comb begin
        o_data = i_rf_data;
        o_hit  = 1'b0;
        for (int i = HISTORY_DEPTH - 1; i >= 0; i--) begin
            if (i_sel[i]) begin
                o_data = i_entry_data[i*LANE_WIDTH +: LANE_WIDTH];
                o_hit  = 1'b1;
            end
        end
    end

endmodule : bypass_lane_select
`default_nettype wire

// File: rtl/writeback_bypass_history.sv
`default_nettype none
// ============================================================================
// Module      : writeback_bypass_history
// Description : Keeps the last HISTORY_DEPTH committed writebacks and patches
//               stale register-file read data on READ_PORTS operand ports.
//               Per lane, the newest matching entry wins. Scalar and vector
//               registers live in separate namespaces.
// Ports       : clk, reset (async, active-high), flush (sync invalidate)
//               wb_*      - committed writeback (scalar or vector)
//               rd_sel / rd_is_vector / rd_rf_value - per-port read request
//               rd_value / rd_hit - combinational corrected data and hit
//               pc_event_bypass_hit - registered "any hit last cycle"
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_bypass_history
    import writeback_bypass_history_pkg::*;
#(
    parameter int HISTORY_DEPTH = 2,
    parameter int READ_PORTS    = 2,
    parameter int LANES         = C_LANES,
    parameter int REG_IDX_WIDTH = C_REG_IDX_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic                                    wb_scalar_en,
    input  logic                                    wb_vector_en,
    input  logic [REG_IDX_WIDTH-1:0]                wb_reg,
    input  logic [LANES*C_LANE_WIDTH-1:0]           wb_value,
    input  logic [LANES-1:0]                        wb_mask,
    input  logic [READ_PORTS*REG_IDX_WIDTH-1:0]     rd_sel,
    input  logic [READ_PORTS-1:0]                   rd_is_vector,
    input  logic [READ_PORTS*LANES*C_LANE_WIDTH-1:0] rd_rf_value,
    output logic [READ_PORTS*LANES*C_LANE_WIDTH-1:0] rd_value,
    output logic [READ_PORTS-1:0]                   rd_hit,
    output logic                                    pc_event_bypass_hit
);

    localparam int C_LW = C_LANE_WIDTH;

    bypass_entry_t r_hist [HISTORY_DEPTH];
    bypass_entry_t w_new_entry;
    logic          w_wb_en;
    logic          r_bypass_hit_evt;

    assign w_wb_en = wb_scalar_en | wb_vector_en;

    // A simultaneous scalar+vector request is captured as a vector write.
    always_comb begin
        w_new_entry           = '0;
        w_new_entry.valid     = 1'b1;
        w_new_entry.is_vector = wb_vector_en;
        w_new_entry.reg_idx   = wb_reg;
        w_new_entry.mask      = capture_mask(wb_vector_en, wb_mask);
        w_new_entry.value     = wb_value;
    end

    // History only ages on real writebacks; idle cycles hold it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HISTORY_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < HISTORY_DEPTH; i++) begin
                r_hist[i].valid <= 1'b0;
            end
        end else if (w_wb_en) begin
            r_hist[0] <= w_new_entry;
            for (int i = 1; i < HISTORY_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    generate
        for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
            logic [HISTORY_DEPTH-1:0] w_match;
            logic [LANES-1:0]         w_lane_hit;

            for (genvar i = 0; i < HISTORY_DEPTH; i++) begin : g_match
                assign w_match[i] = r_hist[i].valid
                                  && (r_hist[i].reg_idx == rd_sel[p*REG_IDX_WIDTH +: REG_IDX_WIDTH])
                                  && (r_hist[i].is_vector == rd_is_vector[p]);
            end

            // Scalar entries own only lane 0, so a scalar port naturally
            // patches [31:0] and passes the upper lanes through.
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                logic [HISTORY_DEPTH-1:0]      w_lane_sel;
                logic [HISTORY_DEPTH*C_LW-1:0] w_lane_data;

                for (genvar i = 0; i < HISTORY_DEPTH; i++) begin : g_ent
                    assign w_lane_sel[i]               = w_match[i] & r_hist[i].mask[l];
                    assign w_lane_data[i*C_LW +: C_LW] = r_hist[i].value[l*C_LW +: C_LW];
                end

                bypass_lane_select #(
                    .HISTORY_DEPTH (HISTORY_DEPTH),
                    .LANE_WIDTH    (C_LW)
                ) u_lane_select (
                    .i_sel        (w_lane_sel),
                    .i_entry_data (w_lane_data),
                    .i_rf_data    (rd_rf_value[(p*LANES+l)*C_LW +: C_LW]),
                    .o_data       (rd_value[(p*LANES+l)*C_LW +: C_LW]),
                    .o_hit        (w_lane_hit[l])
                );
            end

            assign rd_hit[p] = |w_lane_hit;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bypass_hit_evt <= 1'b0;
        end else begin
            r_bypass_hit_evt <= |rd_hit;
        end
    end

    assign pc_event_bypass_hit = r_bypass_hit_evt;

    a_single_wb_kind : assert property (@(posedge clk) disable iff (reset)
        !(wb_scalar_en && wb_vector_en));

endmodule : writeback_bypass_history
`default_nettype wire

// File: tb/tb_writeback_bypass_history.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_bypass_history
// Description : Self-checking bench. The driver issues one request per cycle
//               and pushes the reference model's expected outputs into a
//               scoreboard; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_bypass_history;

    localparam int DEPTH = 2;
    localparam int RP    = 2;
    localparam int LN    = 16;
    localparam int RW    = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              wb_scalar_en;
    logic              wb_vector_en;
    logic [RW-1:0]     wb_reg;
    logic [LN*32-1:0]  wb_value;
    logic [LN-1:0]     wb_mask;
    logic [RP*RW-1:0]  rd_sel;
    logic [RP-1:0]     rd_is_vector;
    logic [RP*LN*32-1:0] rd_rf_value;
    logic [RP*LN*32-1:0] rd_value;
    logic [RP-1:0]     rd_hit;
    logic              pc_event_bypass_hit;

    writeback_bypass_history #(
        .HISTORY_DEPTH (DEPTH),
        .READ_PORTS    (RP),
        .LANES         (LN),
        .REG_IDX_WIDTH (RW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .wb_scalar_en        (wb_scalar_en),
        .wb_vector_en        (wb_vector_en),
        .wb_reg              (wb_reg),
        .wb_value            (wb_value),
        .wb_mask             (wb_mask),
        .rd_sel              (rd_sel),
        .rd_is_vector        (rd_is_vector),
        .rd_rf_value         (rd_rf_value),
        .rd_value            (rd_value),
        .rd_hit              (rd_hit),
        .pc_event_bypass_hit (pc_event_bypass_hit)
    );

    always #5 clk = ~clk;

    // Reference model: list of committed writes, newest first.
    typedef struct {
        bit              vec;
        logic [RW-1:0]   r;
        logic [LN*32-1:0] val;
        logic [LN-1:0]   mask;
    } hent_t;

    typedef struct {
        logic [RP*LN*32-1:0] v;
        logic [RP-1:0]       h;
        logic                e;
    } exp_t;

    hent_t hist[$];
    exp_t  sb[$];
    logic  m_last_hit = 1'b0;
    logic  m_evt      = 1'b0;
    int    n_checks   = 0;
    int    n_pass     = 0;

    function automatic logic [LN*32-1:0] rep(input logic [31:0] x);
        return {LN{x}};
    endfunction

    function automatic logic [LN*32-1:0] rnd512();
        logic [LN*32-1:0] r;
        for (int i = 0; i < LN; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Apply what the DUT saw at the clock edge just taken.
    task automatic model_edge();
        hent_t e;
        if (reset) begin
            hist.delete();
            m_evt = 1'b0;
        end else begin
            m_evt = m_last_hit;
            if (flush) begin
                hist.delete();
            end else if (wb_scalar_en || wb_vector_en) begin
                e.vec  = wb_vector_en;
                e.r    = wb_reg;
                e.val  = wb_value;
                e.mask = wb_mask;
                hist.push_front(e);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
        end
    endtask

    task automatic push_expect();
        exp_t x;
        bit   own;
        x.v = rd_rf_value;
        x.h = '0;
        for (int p = 0; p < RP; p++) begin
            for (int l = 0; l < LN; l++) begin
                for (int i = 0; i < hist.size(); i++) begin
                    own = hist[i].vec ? hist[i].mask[l] : (l == 0);
                    if (hist[i].r == rd_sel[p*RW +: RW] && hist[i].vec == rd_is_vector[p] && own) begin
                        x.v[(p*LN+l)*32 +: 32] = hist[i].val[l*32 +: 32];
                        x.h[p] = 1'b1;
                        break;
                    end
                end
            end
        end
        x.e = m_evt;
        m_last_hit = |x.h;
        sb.push_back(x);
    endtask

    task automatic step(input logic rst_v, input logic fl, input logic se, input logic ve,
                        input logic [RW-1:0] wr, input logic [LN*32-1:0] wv, input logic [LN-1:0] wm,
                        input logic [RW-1:0] s0, input logic [RW-1:0] s1, input logic [RP-1:0] isv,
                        input logic [RP*LN*32-1:0] rf);
        @(posedge clk);
        model_edge();
        #1;
        reset = rst_v;
        if (rst_v) begin
            hist.delete();
            m_evt = 1'b0;
        end
        flush        = fl;
        wb_scalar_en = se;
        wb_vector_en = ve;
        wb_reg       = wr;
        wb_value     = wv;
        wb_mask      = wm;
        rd_sel       = {s1, s0};
        rd_is_vector = isv;
        rd_rf_value  = rf;
        push_expect();
    endtask

    task automatic random_steps(input int n);
        int kind;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 2);
            step(1'b0, ($urandom_range(0, 15) == 0), kind == 1, kind == 2,
                 RW'($urandom_range(0, 3)), rnd512(), LN'($urandom),
                 RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RP'($urandom),
                 {rnd512(), rnd512()});
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            if (rd_value === x.v) n_pass++;
            else $display("FAIL rd_value: got %h required %h", rd_value, x.v);
            n_checks++;
            if (rd_hit === x.h) n_pass++;
            else $display("FAIL rd_hit: got %b required %b", rd_hit, x.h);
            n_checks++;
            if (pc_event_bypass_hit === x.e) n_pass++;
            else $display("FAIL pc_event_bypass_hit: got %b required %b", pc_event_bypass_hit, x.e);
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; wb_scalar_en = 1'b0; wb_vector_en = 1'b0;
        wb_reg = '0; wb_value = '0; wb_mask = '0;
        rd_sel = '0; rd_is_vector = '0; rd_rf_value = '0;
        repeat (2) @(posedge clk);

        // Empty history: pass-through
        step(0, 0, 0, 0, 0, 0, 0, 5, 5, 2'b11, {2{rep(32'hAAAAAAAA)}});
        // Vector v5 lanes 0-7, then read
        step(0, 0, 0, 1, 5, rep(32'h11111111), 16'h00FF, 9, 9, 2'b00, '0);
        step(0, 0, 0, 0, 0, 0, 0, 5, 5, 2'b11, '0);
        step(0, 0, 0, 0, 0, 0, 0, 9, 9, 2'b00, '0);
        // Newest wins per lane
        step(0, 0, 0, 1, 5, rep(32'h1), 16'hFFFF, 9, 9, 2'b00, '0);
        step(0, 0, 0, 1, 5, rep(32'h2), 16'h000F, 9, 9, 2'b00, '0);
        step(0, 0, 0, 0, 0, 0, 0, 5, 5, 2'b11, {2{rep(32'h33333333)}});
        // Three scalar writes, depth 2: s1 aged out
        step(0, 0, 1, 0, 1, rep(32'h7), 16'hFFFF, 9, 9, 2'b00, '0);
        step(0, 0, 1, 0, 2, rep(32'h8), 16'hFFFF, 9, 9, 2'b00, '0);
        step(0, 0, 1, 0, 3, rep(32'h9), 16'hFFFF, 9, 9, 2'b00, '0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 2'b00, {rep(32'hDEADBEEF), rep(32'h0)});
        // Namespace separation
        step(0, 0, 1, 0, 4, 512'h55, 16'h0, 9, 9, 2'b00, '0);
        step(0, 0, 0, 0, 0, 0, 0, 4, 4, 2'b01, {2{rep(32'hCCCCCCCC)}});
        // Flush beats simultaneous writeback
        step(0, 1, 0, 1, 6, rep(32'h66666666), 16'hFFFF, 9, 9, 2'b00, '0);
        step(0, 0, 0, 0, 0, 0, 0, 6, 6, 2'b11, {2{rep(32'h12345678)}});

        random_steps(300);

        // Asynchronous reset in the middle of traffic
        step(0, 0, 0, 1, 2, rep(32'hBEEF0002), 16'hFFFF, 2, 2, 2'b11, '0);
        step(1, 0, 0, 0, 0, 0, 0, 2, 2, 2'b11, {2{rep(32'h0F0F0F0F)}});
        step(1, 0, 0, 0, 0, 0, 0, 2, 2, 2'b11, {2{rep(32'hF0F0F0F0)}});
        step(0, 0, 0, 0, 0, 0, 0, 2, 2, 2'b11, {2{rep(32'h5A5A5A5A)}});

        random_steps(300);

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, '0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_writeback_bypass_history
`default_nettype wire
